axi_slave_write_responder: RTL and testbench
============================================

// Module: axi_slave_write_responder
// PURPOSE
//  Synthesizable AXI write-channel slave with byte-writable internal memory; sink for the master agent's AW/W/B.
//  Accepts one burst at a time: AW handshake, then WLEN+1 W beats, then a single B response.
//  Debug read port lets the bench check memory contents without driving the read channels.
// PARAMETERS
//  ADDR_WIDTH  32    AWADDR width
//  DATA_WIDTH  32    WDATA width; power of 2, 8..128; ADDR_LSB = log2(DATA_WIDTH/8)
//  MEM_DEPTH   256   memory words; power of 2; MEM_AW = log2(MEM_DEPTH)
// PORTS
//  ACLK      in   1             clock; all logic on rising edge
//  ARESET    in   1             asynchronous, active-high reset
//  AWID      in   8             write ID, captured on AW handshake
//  AWADDR    in   ADDR_WIDTH    burst start byte address
//  AWLEN     in   8             beats-1
//  AWSIZE    in   3             log2 bytes per beat
//  AWBURST   in   2             00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  AWVALID   in   1             address valid
//  AWREADY   out  1             address ready (registered)
//  WID       in   8             ignored
//  WDATA     in   DATA_WIDTH    write data
//  WSTRB     in   DATA_WIDTH/8  byte enables
//  WLAST     in   1             last beat marker
//  WVALID    in   1             data valid
//  WREADY    out  1             data ready (registered)
//  BID       out  8             = captured AWID
//  BRESP     out  2             00 OKAY, 10 SLVERR, 11 DECERR
//  BVALID    out  1             response valid
//  BREADY    in   1             response ready
//  DBG_ADDR  in   MEM_AW        debug word index
//  DBG_DATA  out  DATA_WIDTH    combinational mem[DBG_ADDR]
// BEHAVIOUR
//  Reset: AWREADY=0 WREADY=0 BVALID=0 BID=0 BRESP=0, FSM=IDLE, beat counter=0; memory NOT reset.
//   Reset mid-burst abandons the burst, no B issued; AWREADY=1 first edge after ARESET falls.
//  FSM: IDLE (AWREADY=1) -AWVALID&AWREADY-> DATA (WREADY=1) -final beat-> RESP (BVALID=1) -BVALID&BREADY-> IDLE.
//  Latency: AW handshake at edge N -> WREADY=1 after N; final W handshake at M -> BVALID=1 after M;
//   B handshake at K -> AWREADY=1 after K. One outstanding burst; AW never accepted in DATA/RESP.
//  BVALID/BID/BRESP held stable until BREADY sampled high.
//  Beat address: beat0=AWADDR; FIXED: unchanged; INCR: +(1<<AWSIZE), wraps mod 2^ADDR_WIDTH;
//   WRAP: span=(AWLEN+1)<<AWSIZE, addr low bits wrap within span-aligned window.
//  Write: word=addr[ADDR_LSB +: MEM_AW]; byte lane i written iff WSTRB[i]; strobes used as given.
//  Illegal burst -> all beats accepted, no memory writes, BRESP=SLVERR:
//   AWBURST=11; AWSIZE>ADDR_LSB; WRAP with AWLEN not in {1,3,7,15}.
//  Out of range: any beat with (addr>>ADDR_LSB)>=MEM_DEPTH -> that beat dropped; BRESP=DECERR.
//  BRESP priority: SLVERR > DECERR > OKAY. Beat counter 8 bits; final beat = beat AWLEN.
//  W channel stalled (WREADY=0) outside DATA; WVALID in IDLE/RESP ignored.
// CONFIGURATION
//  AXI_SLV_WLAST_CHECK_EN defined: burst ends on first of WLAST=1 or beat AWLEN;
//   WLAST=1 before beat AWLEN, or WLAST=0 on beat AWLEN -> BRESP=SLVERR (written beats kept).
//  Undefined: WLAST ignored; burst always ends on beat AWLEN.
// TESTING
//  INCR AWADDR=0x10 AWLEN=3 AWSIZE=2 data 0xA0..0xA3 WSTRB=F -> mem[4..7]=A0..A3, BRESP=00, BID=AWID.
//  WRAP AWADDR=0x38 AWLEN=3 AWSIZE=2 -> writes words 14,15,12,13; BRESP=00.
//  FIXED AWADDR=0x20 AWLEN=1 WSTRB 0x3 then 0xC, data 0x11112222,0x33334444 -> mem[8]=0x33332222.
//  AWADDR=0x400 (word 256) AWLEN=0 -> no write, BRESP=11; AWBURST=11 -> BRESP=10, mem unchanged.
//  BREADY low 5 cycles -> BVALID/BRESP/BID stable, AWREADY=0 until B handshake.
//  ARESET pulse after beat 1 of AWLEN=3 -> no BVALID; next burst completes OKAY; WLAST early (macro) -> SLVERR.

Source files
------------

// File: rtl/axi_slave_write_responder.sv
// AXI write-channel slave (AW/W/B) with byte-writable memory and a combinational debug read port.
// Optional macro AXI_SLV_WLAST_CHECK_EN: burst also ends on WLAST, and WLAST misplacement reports SLVERR.

module axi_slave_write_responder_lane #(
  parameter int MEM_DEPTH = 256,
  parameter int MEM_AW    = 8
) (
  input  logic              ACLK,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [7:0]        wbyte,
  input  logic [MEM_AW-1:0] raddr,
  output logic [7:0]        rbyte
);
  logic [7:0] mem [MEM_DEPTH];

  always_ff @(posedge ACLK)
    if (we) mem[waddr] <= wbyte;

  assign rbyte = mem[raddr];
endmodule

module axi_slave_write_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [7:0]                   AWID,
  input  logic [ADDR_WIDTH-1:0]        AWADDR,
  input  logic [7:0]                   AWLEN,
  input  logic [2:0]                   AWSIZE,
  input  logic [1:0]                   AWBURST,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [7:0]                   WID,
  input  logic [DATA_WIDTH-1:0]        WDATA,
  input  logic [DATA_WIDTH/8-1:0]      WSTRB,
  input  logic                         WLAST,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [7:0]                   BID,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  input  logic [$clog2(MEM_DEPTH)-1:0] DBG_ADDR,
  output logic [DATA_WIDTH-1:0]        DBG_DATA
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int MEM_AW   = $clog2(MEM_DEPTH);
  localparam logic [2:0] LSB3 = 3'(ADDR_LSB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  // Burst context captured on the AW handshake; error flags accumulate over the beats.
  typedef struct packed {
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [ADDR_WIDTH-1:0] mask;
    logic                  slverr;
    logic                  decerr;
  } ctx_t;

  logic [1:0]            state_q;
  ctx_t                  ctx_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            beat_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [7:0]            bid_q;
  logic [1:0]            bresp_q;

  logic                  w_hs;
  logic                  aw_illegal;
  logic [ADDR_WIDTH-1:0] aw_mask;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  beat_oor;
  logic                  cnt_last, last_beat, wlast_err;
  logic                  resp_slv, resp_dec;
  logic [1:0]            final_resp;
  logic                  we_all;
  logic                  unused_in;

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;

  assign w_hs = WVALID & wready_q;

  always_comb begin
    aw_illegal = (AWBURST == BURST_RSVD) || (AWSIZE > LSB3) ||
                 ((AWBURST == BURST_WRAP) &&
                  !(AWLEN == 8'd1 || AWLEN == 8'd3 || AWLEN == 8'd7 || AWLEN == 8'd15));
    aw_mask    = ((ADDR_WIDTH'(AWLEN) + ADDR_WIDTH'(1)) << AWSIZE) - ADDR_WIDTH'(1);
  end

  // Address arithmetic for the beat following the current one.
  always_comb begin
    incr = ADDR_WIDTH'(1) << ctx_q.size;
    case (ctx_q.burst)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (addr_q & ~ctx_q.mask) | ((addr_q + incr) & ctx_q.mask);
      default:     next_addr = addr_q + incr;
    endcase
  end

  assign beat_oor = |(addr_q >> (ADDR_LSB + MEM_AW));
  assign cnt_last = (beat_q == ctx_q.len);

`ifdef AXI_SLV_WLAST_CHECK_EN
  assign last_beat = cnt_last | WLAST;
  assign wlast_err = cnt_last ^ WLAST;
`else
  assign last_beat = cnt_last;
  assign wlast_err = 1'b0;
`endif

  assign resp_slv   = ctx_q.slverr | wlast_err;
  assign resp_dec   = ctx_q.decerr | beat_oor;
  assign final_resp = resp_slv ? 2'b10 : (resp_dec ? 2'b11 : 2'b00);

  // Illegal bursts and out-of-range beats never touch memory.
  assign we_all = (state_q == S_DATA) & w_hs & ~ctx_q.slverr & ~beat_oor;

  assign unused_in = ^{WID, WLAST};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      ctx_q     <= '0;
      addr_q    <= '0;
      beat_q    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!awready_q) begin
            awready_q <= 1'b1;
          end else if (AWVALID) begin
            awready_q    <= 1'b0;
            wready_q     <= 1'b1;
            state_q      <= S_DATA;
            bid_q        <= AWID;
            addr_q       <= AWADDR;
            beat_q       <= '0;
            ctx_q.len    <= AWLEN;
            ctx_q.size   <= AWSIZE;
            ctx_q.burst  <= AWBURST;
            ctx_q.mask   <= aw_mask;
            ctx_q.slverr <= aw_illegal;
            ctx_q.decerr <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            addr_q       <= next_addr;
            beat_q       <= beat_q + 8'd1;
            ctx_q.decerr <= resp_dec;
            if (last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= final_resp;
              state_q  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  logic [STRB_W-1:0][7:0] dbg_lane;

  for (genvar k = 0; k < STRB_W; k++) begin : g_lane
    axi_slave_write_responder_lane #(
      .MEM_DEPTH (MEM_DEPTH),
      .MEM_AW    (MEM_AW)
    ) u_lane (
      .ACLK  (ACLK),
      .we    (we_all & WSTRB[k]),
      .waddr (addr_q[ADDR_LSB +: MEM_AW]),
      .wbyte (WDATA[8*k +: 8]),
      .raddr (DBG_ADDR),
      .rbyte (dbg_lane[k])
    );
  end

  assign DBG_DATA = dbg_lane;

endmodule

// File: tb/tb_axi_slave_write_responder.sv
// Directed bench for axi_slave_write_responder: vector table of bursts plus hand-written corner sequences.
module tb_axi_slave_write_responder;
  logic        ACLK, ARESET;
  logic [7:0]  AWID, WID, BID, AWLEN;
  logic [31:0] AWADDR, WDATA, DBG_DATA;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST, BRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic [3:0]  WSTRB;
  logic [7:0]  DBG_ADDR;

  int checks = 0;
  int failures = 0;

  axi_slave_write_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  strb;
    logic [31:0] dbase;
    logic [1:0]  resp;
    logic [7:0]  word;
    logic [31:0] val;
  } vec_t;

  vec_t v[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic mem_chk(input string name, input logic [7:0] word, input logic [31:0] exp);
    DBG_ADDR = word;
    #1;
    chk(name, DBG_DATA, exp);
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    while (AWREADY !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) timeout_fail("aw_wait");
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0;
    chk("aw_then_wready", WREADY, 1);
    chk("aw_then_awready_low", AWREADY, 0);
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    while (WREADY !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) timeout_fail("w_wait");
    @(posedge ACLK); @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic recv_b(output logic [1:0] resp, output logic [7:0] id);
    int n = 0;
    while (BVALID !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) timeout_fail("b_wait");
    resp = BRESP; id = BID;
    @(posedge ACLK); @(negedge ACLK);
    chk("b_cleared", BVALID, 0);
  endtask

  logic [1:0] r;
  logic [7:0] rid;

  initial begin
    v[0] = '{8'h5A, 32'h0000_0010, 8'd3, 3'd2, 2'b01, 4'hF, 32'h0000_00A0, 2'b00, 8'd6,   32'h0000_00A2};
    v[1] = '{8'h21, 32'h0000_0038, 8'd3, 3'd2, 2'b10, 4'hF, 32'h0000_00B0, 2'b00, 8'd12,  32'h0000_00B2};
    v[2] = '{8'h01, 32'h0000_0000, 8'd0, 3'd2, 2'b01, 4'hF, 32'h1234_5678, 2'b00, 8'd0,   32'h1234_5678};
    v[3] = '{8'h02, 32'h0000_0400, 8'd0, 3'd2, 2'b01, 4'hF, 32'hDEAD_0000, 2'b11, 8'd0,   32'h1234_5678};
    v[4] = '{8'h03, 32'h0000_0010, 8'd1, 3'd2, 2'b11, 4'hF, 32'h0000_00EE, 2'b10, 8'd4,   32'h0000_00A0};
    v[5] = '{8'h04, 32'h0000_0014, 8'd2, 3'd2, 2'b10, 4'hF, 32'h0000_00EE, 2'b10, 8'd5,   32'h0000_00A1};
    v[6] = '{8'h05, 32'h0000_0018, 8'd0, 3'd3, 2'b01, 4'hF, 32'h0000_00EE, 2'b10, 8'd6,   32'h0000_00A2};
    v[7] = '{8'h06, 32'h0000_03FC, 8'd1, 3'd2, 2'b01, 4'hF, 32'h0000_00C0, 2'b11, 8'd255, 32'h0000_00C0};
    v[8] = '{8'h07, 32'h0000_0010, 8'd0, 3'd2, 2'b01, 4'h2, 32'h0000_5500, 2'b00, 8'd4,   32'h0000_55A0};

    ARESET = 1'b1; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1; DBG_ADDR = '0;

    repeat (3) @(negedge ACLK);
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_bid", BID, 0);
    chk("rst_bresp", BRESP, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_release_awready", AWREADY, 1);

    for (int i = 0; i < 9; i++) begin
      send_aw(v[i].id, v[i].addr, v[i].len, v[i].size, v[i].burst);
      for (int b = 0; b <= int'(v[i].len); b++)
        w_beat(v[i].dbase + 32'(b), v[i].strb, b == int'(v[i].len));
      recv_b(r, rid);
      chk($sformatf("vec%0d_bresp", i), r, v[i].resp);
      chk($sformatf("vec%0d_bid", i), rid, v[i].id);
      mem_chk($sformatf("vec%0d_mem", i), v[i].word, v[i].val);
    end
    mem_chk("incr_w5", 8'd5, 32'hA1);
    mem_chk("incr_w7", 8'd7, 32'hA3);
    mem_chk("wrap_w13", 8'd13, 32'hB3);
    mem_chk("wrap_w14", 8'd14, 32'hB0);
    mem_chk("wrap_w15", 8'd15, 32'hB1);

    // FIXED burst with complementary strobes merges into one word
    send_aw(8'h31, 32'h20, 8'd1, 3'd2, 2'b00);
    w_beat(32'h1111_2222, 4'h3, 1'b0);
    w_beat(32'h3333_4444, 4'hC, 1'b1);
    recv_b(r, rid);
    chk("fixed_bresp", r, 2'b00);
    mem_chk("fixed_w8", 8'd8, 32'h3333_2222);

    // B backpressure: response held, no new AW
    BREADY = 1'b0;
    send_aw(8'h77, 32'h80, 8'd0, 3'd2, 2'b01);
    w_beat(32'hCAFE_0001, 4'hF, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk("stall_bvalid", BVALID, 1);
      chk("stall_bid", BID, 8'h77);
      chk("stall_bresp", BRESP, 2'b00);
      chk("stall_awready", AWREADY, 0);
      @(negedge ACLK);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    chk("stall_release_bvalid", BVALID, 0);
    chk("stall_release_awready", AWREADY, 1);
    mem_chk("stall_w32", 8'd32, 32'hCAFE_0001);

    // reset in the middle of a burst
    send_aw(8'h44, 32'h90, 8'd3, 3'd2, 2'b01);
    w_beat(32'h0000_00D0, 4'hF, 1'b0);
    w_beat(32'h0000_00D1, 4'hF, 1'b0);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("midrst_wready", WREADY, 0);
    chk("midrst_bvalid", BVALID, 0);
    chk("midrst_awready", AWREADY, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("midrst_awready_back", AWREADY, 1);
    chk("midrst_no_b", BVALID, 0);
    mem_chk("midrst_w36", 8'd36, 32'hD0);
    mem_chk("midrst_w37", 8'd37, 32'hD1);
    send_aw(8'h45, 32'hA0, 8'd0, 3'd2, 2'b01);
    w_beat(32'h0000_00E0, 4'hF, 1'b1);
    recv_b(r, rid);
    chk("post_rst_bresp", r, 2'b00);
    chk("post_rst_bid", rid, 8'h45);
    mem_chk("post_rst_w40", 8'd40, 32'hE0);

    // early WLAST on a two-beat burst
    send_aw(8'h50, 32'hC0, 8'd1, 3'd2, 2'b01);
    w_beat(32'h0000_00F0, 4'hF, 1'b1);
`ifdef AXI_SLV_WLAST_CHECK_EN
    recv_b(r, rid);
    chk("wlast_early_bresp", r, 2'b10);
    mem_chk("wlast_early_w48", 8'd48, 32'hF0);
`else
    w_beat(32'h0000_00F1, 4'hF, 1'b0);
    recv_b(r, rid);
    chk("wlast_ignored_bresp", r, 2'b00);
    mem_chk("wlast_ignored_w49", 8'd49, 32'hF1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
